// File: rtl/div_ratio_ctrl.sv
// Purpose : glitch-safe controller that loads a new divide ratio / enable into a
//           downstream clock divider, applying changes only at a divided-clock
//           falling edge, or after a timeout if that edge never comes.
// Latency : bypass apply 1 cycle after acceptance; otherwise 1 cycle after the
//           first safe point, or TMO_CYC cycles in WAIT_SAFE; then SETTLE_CYC busy.
// Backpressure: o_busy high from the cycle after acceptance until settle ends;
//           any i_cfg_valid seen while busy is dropped without error.
// Ports   : i_ref_clk/i_rst (async active-low) clock and reset;
//           i_cfg_valid/i_prescale/i_div_en configuration request;
//           i_div_clk_fb divided-clock feedback;
//           o_div_ratio/o_clk_en divider controls; o_busy request in progress;
//           o_cfg_err illegal-prescale pulse; o_tmo forced-apply pulse.
module div_ratio_ctrl #(
  parameter int RATIO_WD   = 4,
  parameter int TMO_CYC    = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_cfg_valid,
  input  logic [5:0]          i_prescale,
  input  logic                i_div_en,
  input  logic                i_div_clk_fb,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic                o_busy,
  output logic                o_cfg_err,
  output logic                o_tmo
);

  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SAFE,
    APPLY,
    SETTLE
  } state_e;

  state_e              state_q;
  logic                fb_q;
  logic [TW-1:0]       tmo_cnt_q;
  logic [SW-1:0]       settle_cnt_q;
  logic [RATIO_WD-1:0] pend_ratio_q;
  logic                pend_en_q;

  logic [RATIO_WD-1:0] req_ratio_d;
  logic                req_legal_d;
  logic                bypass;
  logic                safe_pt;

  // Prescale is the oversampling factor; the divider ratio is its inverse
  // relative to 32x, so only the four power-of-two values are meaningful.
  always_comb begin
    req_ratio_d = '0;
    req_legal_d = 1'b1;
    case (i_prescale)
      6'd32:   req_ratio_d = RATIO_WD'(1);
      6'd16:   req_ratio_d = RATIO_WD'(2);
      6'd8:    req_ratio_d = RATIO_WD'(4);
      6'd4:    req_ratio_d = RATIO_WD'(8);
      default: req_legal_d = 1'b0;
    endcase
  end

  // With the divider off or passing the clock through there is no feedback
  // edge to wait for, so the change can be applied straight away.
  assign bypass  = ~o_clk_en | (o_div_ratio < RATIO_WD'(2));
  // Falling edge of the divided clock: the divider is at a safe point to retune.
  assign safe_pt = fb_q & ~i_div_clk_fb;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      fb_q         <= 1'b0;
      tmo_cnt_q    <= '0;
      settle_cnt_q <= '0;
      pend_ratio_q <= RATIO_WD'(1);
      pend_en_q    <= 1'b0;
      o_div_ratio  <= RATIO_WD'(1);
      o_clk_en     <= 1'b0;
      o_busy       <= 1'b0;
      o_cfg_err    <= 1'b0;
      o_tmo        <= 1'b0;
    end else begin
      fb_q      <= i_div_clk_fb;
      o_cfg_err <= 1'b0;
      o_tmo     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cfg_valid) begin
            if (!req_legal_d) begin
              o_cfg_err <= 1'b1;
            end else begin
              pend_ratio_q <= req_ratio_d;
              pend_en_q    <= i_div_en;
              o_busy       <= 1'b1;
              if (bypass) begin
                state_q <= APPLY;
              end else begin
                state_q   <= WAIT_SAFE;
                tmo_cnt_q <= '0;
              end
            end
          end
        end
        WAIT_SAFE: begin
          // Safe point wins over timeout when both land on the same cycle.
          if (safe_pt) begin
            state_q <= APPLY;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= APPLY;
            o_tmo   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        APPLY: begin
          o_div_ratio  <= pend_ratio_q;
          o_clk_en     <= pend_en_q;
          state_q      <= SETTLE;
          settle_cnt_q <= '0;
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + SW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Purpose : directed bench for div_ratio_ctrl with a timestamp-based reference
//           model checked on every cycle, plus literal timing/value checks.
// Ports   : none (top-level bench).
module tb_div_ratio_ctrl;

  localparam int RW  = 4;
  localparam int TMO = 64;
  localparam int SET = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [5:0]    prescale  = '0;
  logic          div_en    = 1'b0;
  logic          fb        = 1'b0;
  logic [RW-1:0] div_ratio;
  logic          clk_en, busy, cfg_err, tmo;

  int checks = 0;
  int errors = 0;
  int n_tmo  = 0;
  int n_err  = 0;

  always #5 clk = ~clk;

  div_ratio_ctrl #(.RATIO_WD(RW), .TMO_CYC(TMO), .SETTLE_CYC(SET)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst_n),
    .i_cfg_valid (cfg_valid),
    .i_prescale  (prescale),
    .i_div_en    (div_en),
    .i_div_clk_fb(fb),
    .o_div_ratio (div_ratio),
    .o_clk_en    (clk_en),
    .o_busy      (busy),
    .o_cfg_err   (cfg_err),
    .o_tmo       (tmo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks the controller in terms of "what is pending",
  // "how long have we waited" and "when does busy end", using cycle stamps.
  int      m_ratio = 1;
  bit      m_en = 0, m_busy = 0, m_err = 0, m_tmo = 0, m_fb = 0;
  bit      m_wait = 0, m_apply = 0, m_pe = 0;
  int      m_wn = 0, m_pr = 1;
  longint  cyc = 0, m_clr = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ratio = 1; m_en = 0; m_busy = 0; m_err = 0; m_tmo = 0; m_fb = 0;
      m_wait = 0; m_apply = 0; m_wn = 0; m_clr = -1;
    end else begin
      cyc++;
      m_err = 0;
      m_tmo = 0;
      if (m_apply) begin
        m_ratio = m_pr; m_en = m_pe; m_apply = 0;
        m_clr = cyc + SET;
      end else if (m_wait) begin
        m_wn++;
        if (m_fb && !fb) begin
          m_wait = 0; m_apply = 1;
        end else if (m_wn == TMO) begin
          m_wait = 0; m_apply = 1; m_tmo = 1;
        end
      end else if (m_busy) begin
        if (cyc == m_clr) m_busy = 0;
      end else if (cfg_valid) begin
        if (prescale inside {6'd4, 6'd8, 6'd16, 6'd32}) begin
          m_pr = 32 / int'(prescale);
          m_pe = div_en;
          m_busy = 1;
          if (!m_en || m_ratio < 2) m_apply = 1;
          else begin m_wait = 1; m_wn = 0; end
        end else begin
          m_err = 1;
        end
      end
      m_fb = fb;
    end
  end

  // Per-cycle comparison against the model, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    chk("ratio",   32'(div_ratio), 32'(m_ratio));
    chk("clk_en",  32'(clk_en),    32'(m_en));
    chk("busy",    32'(busy),      32'(m_busy));
    chk("cfg_err", 32'(cfg_err),   32'(m_err));
    chk("tmo",     32'(tmo),       32'(m_tmo));
    if (tmo)     n_tmo++;
    if (cfg_err) n_err++;
  end

  task automatic send(input logic [5:0] p, input logic e);
    @(negedge clk);
    cfg_valid = 1'b1; prescale = p; div_en = e;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, t0, e0;

    repeat (3) @(negedge clk);
    chk("rst_ratio", 32'(div_ratio), 32'd1);
    chk("rst_en",    32'(clk_en),    32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst_n = 1'b1;

    // Bypass load straight out of reset: no wait, 1+SETTLE busy cycles.
    send(6'd8, 1'b1);
    chk("byp_busy_rise", 32'(busy),      32'd1);
    chk("byp_ratio_old", 32'(div_ratio), 32'd1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) n++;
      if (i == 1) begin
        chk("byp_ratio", 32'(div_ratio), 32'd4);
        chk("byp_en",    32'(clk_en),    32'd1);
      end
      @(negedge clk);
    end
    chk("byp_busy_len", 32'(n), 32'(1 + SET));

    // Safe-point load at ratio 4: apply one cycle after the fb falling edge.
    t0 = n_tmo;
    fb = 1'b1;
    send(6'd4, 1'b1);
    repeat (3) @(negedge clk);
    chk("sp_still_old", 32'(div_ratio), 32'd4);
    fb = 1'b0;
    @(negedge clk);
    chk("sp_apply_cyc", 32'(div_ratio), 32'd4);
    @(negedge clk);
    chk("sp_ratio", 32'(div_ratio), 32'd8);
    wait_idle("sp_idle");
    chk("sp_no_tmo", 32'(n_tmo - t0), 32'd0);

    // Timeout: fb stuck high, forced apply after TMO cycles in WAIT_SAFE.
    t0 = n_tmo;
    fb = 1'b1;
    send(6'd16, 1'b1);
    n = 0;
    while (!tmo && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", 32'(n), 32'(TMO));
    @(negedge clk);
    chk("tmo_ratio", 32'(div_ratio), 32'd2);
    wait_idle("tmo_idle");
    chk("tmo_once", 32'(n_tmo - t0), 32'd1);

    // Safe point lands on the timeout cycle: safe point wins, no o_tmo.
    t0 = n_tmo;
    send(6'd32, 1'b1);
    repeat (TMO - 1) @(negedge clk);
    fb = 1'b0;
    @(negedge clk);
    chk("coin_no_tmo", 32'(tmo), 32'd0);
    @(negedge clk);
    chk("coin_ratio", 32'(div_ratio), 32'd1);
    wait_idle("coin_idle");
    chk("coin_tmo_cnt", 32'(n_tmo - t0), 32'd0);

    // Illegal prescale: one error pulse, nothing else moves.
    e0 = n_err;
    send(6'd12, 1'b1);
    chk("ill_err",   32'(cfg_err),   32'd1);
    chk("ill_busy",  32'(busy),      32'd0);
    chk("ill_ratio", 32'(div_ratio), 32'd1);
    repeat (3) @(negedge clk);
    chk("ill_once", 32'(n_err - e0), 32'd1);

    // Request while busy (during SETTLE) is dropped.
    send(6'd8, 1'b1);
    @(negedge clk);
    send(6'd32, 1'b0);
    wait_idle("vb_idle");
    repeat (2) @(negedge clk);
    chk("vb_ratio", 32'(div_ratio), 32'd4);
    chk("vb_en",    32'(clk_en),    32'd1);

    // Same configuration again still walks the full sequence.
    fb = 1'b1;
    send(6'd8, 1'b1);
    chk("same_busy", 32'(busy), 32'd1);
    @(negedge clk);
    fb = 1'b0;
    wait_idle("same_idle");

    // Reset while waiting for a safe point: outputs drop at once, request lost.
    fb = 1'b1;
    send(6'd4, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ratio", 32'(div_ratio), 32'd1);
    chk("arst_en",    32'(clk_en),    32'd0);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_tmo",   32'(tmo),       32'd0);
    chk("arst_err",   32'(cfg_err),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fb = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst_no_apply", 32'(div_ratio), 32'd1);

    // First request after release is accepted immediately.
    send(6'd16, 1'b1);
    chk("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("post_rst_idle");
    chk("post_rst_ratio", 32'(div_ratio), 32'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
